// File: rtl/muldiv_ctrl_if.sv
// Control-unit <-> HI/LO multiply/divide sequencer bundle.
// master = control unit side, slave = sequencer side.
interface muldiv_ctrl_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, hi_we, lo_we, wdata,
    input  busy, done, div_by_zero, hi, lo
  );

  modport slave (
    input  start, op, a, b, hi_we, lo_we, wdata,
    output busy, done, div_by_zero, hi, lo
  );
endinterface

// File: rtl/muldiv_ctrl.sv
// Multicycle MULT/MULTU/DIV/DIVU sequencer owning HI/LO; one bit per clock.
// Optional build macro MULDIV_EARLY_OUT_EN: multiply leaves ITER once the multiplier is exhausted.
module muldiv_ctrl #(
  parameter int WIDTH = 32
) (
  input logic         clk,
  input logic         rst,
  muldiv_ctrl_if.slave bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [2:0] {IDLE, PREP, ITER, FIX, DONE} state_t;

  state_t state, state_next;

  logic [1:0]         op_r;
  logic [WIDTH-1:0]   a_r, b_r;
  logic [2*WIDTH-1:0] acc, mcand;
  logic [WIDTH-1:0]   mplr;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   hi_r, lo_r;
  logic               dbz;

  logic               is_div, is_signed, sa, sb, last_iter;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     trial, diff;
  logic               qbit;
  logic [WIDTH-1:0]   rem_next;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  assign is_div    = op_r[1];
  assign is_signed = ~op_r[0];
  assign sa        = is_signed & a_r[WIDTH-1];
  assign sb        = is_signed & b_r[WIDTH-1];
  assign mag_a     = sa ? (~a_r + 1'b1) : a_r;
  assign mag_b     = sb ? (~b_r + 1'b1) : b_r;

  // Divide: acc holds {remainder, quotient/dividend}; divisor sits in mcand's low half.
  assign trial    = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
  assign diff     = trial - {1'b0, mcand[WIDTH-1:0]};
  assign qbit     = (trial >= {1'b0, mcand[WIDTH-1:0]});
  assign rem_next = qbit ? diff[WIDTH-1:0] : trial[WIDTH-1:0];

  assign prod_fix = (sa ^ sb) ? (~acc + 1'b1) : acc;
  assign quo_fix  = (sa ^ sb) ? (~acc[WIDTH-1:0] + 1'b1) : acc[WIDTH-1:0];
  assign rem_fix  = sa ? (~acc[2*WIDTH-1:WIDTH] + 1'b1) : acc[2*WIDTH-1:WIDTH];

`ifdef MULDIV_EARLY_OUT_EN
  // mplr is checked pre-shift: its upper bits being zero means this edge empties it.
  assign last_iter = (cnt == CW'(WIDTH-1)) || (!is_div && (mplr[WIDTH-1:1] == '0));
`else
  assign last_iter = (cnt == CW'(WIDTH-1));
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (bus.start) state_next = PREP;
      PREP: state_next = (is_div && (b_r == '0)) ? DONE : ITER;
      ITER: if (last_iter) state_next = FIX;
      FIX:  state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_r  <= '0;
      a_r   <= '0;
      b_r   <= '0;
      acc   <= '0;
      mcand <= '0;
      mplr  <= '0;
      cnt   <= '0;
      hi_r  <= '0;
      lo_r  <= '0;
      dbz   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            op_r <= bus.op;
            a_r  <= bus.a;
            b_r  <= bus.b;
            dbz  <= 1'b0;
          end else begin
            if (bus.hi_we) hi_r <= bus.wdata;
            if (bus.lo_we) lo_r <= bus.wdata;
          end
        end
        PREP: begin
          cnt  <= '0;
          mplr <= mag_b;
          if (is_div) begin
            acc   <= {{WIDTH{1'b0}}, mag_a};
            mcand <= {{WIDTH{1'b0}}, mag_b};
            if (b_r == '0) begin
              dbz  <= 1'b1;
              hi_r <= a_r;
              lo_r <= '1;
            end
          end else begin
            acc   <= '0;
            mcand <= {{WIDTH{1'b0}}, mag_a};
          end
        end
        ITER: begin
          cnt <= cnt + 1'b1;
          if (is_div) begin
            acc <= {rem_next, acc[WIDTH-2:0], qbit};
          end else begin
            if (mplr[0]) acc <= acc + mcand;
            mcand <= mcand << 1;
            mplr  <= mplr >> 1;
          end
        end
        FIX: begin
          if (is_div) begin
            hi_r <= rem_fix;
            lo_r <= quo_fix;
          end else begin
            hi_r <= prod_fix[2*WIDTH-1:WIDTH];
            lo_r <= prod_fix[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy        = (state != IDLE);
  assign bus.done        = (state == DONE);
  assign bus.div_by_zero = dbz;
  assign bus.hi          = hi_r;
  assign bus.lo          = lo_r;
endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: directed cases plus randomized ops against
// an arithmetic reference model (64-bit products, SV integer divide).
module tb_muldiv_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  muldiv_ctrl_if #(.WIDTH(32)) bus ();
  muldiv_ctrl #(.WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  function automatic logic [63:0] ref_result(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy;
    logic [63:0] q, r;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (o)
      2'b00: return sx * sy;
      2'b01: return {32'b0, x} * {32'b0, y};
      default: begin
        if (y == 0) return {x, 32'hFFFFFFFF};
        if (o == 2'b10) begin q = sx / sy; r = sx % sy; end
        else begin q = {32'b0, x / y}; r = {32'b0, x % y}; end
        return {r[31:0], q[31:0]};
      end
    endcase
  endfunction

  // Edges after the start-sampling edge until done is visible.
  function automatic int ref_latency(input logic [1:0] o, input logic [31:0] y);
    int n;
    logic [31:0] m;
    if (o[1]) return (y == 0) ? 1 : 34;
    n = 32;
`ifdef MULDIV_EARLY_OUT_EN
    m = (o == 2'b00 && y[31]) ? -y : y;
    n = 1;
    for (int i = 0; i < 32; i++) if (m[i]) n = i + 1;
`else
    m = y;
`endif
    return n + 2;
  endfunction

  // Caller must be at a negedge with the DUT idle. Returns at the negedge where done is seen.
  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        output int lat, output bit busy_ok);
    bus.start = 1'b1; bus.op = o; bus.a = x; bus.b = y;
    @(negedge clk);
    bus.start = 1'b0;
    lat = -1;
    busy_ok = 1'b1;
    for (int k = 0; k < 100; k++) begin
      if (bus.busy !== 1'b1) busy_ok = 1'b0;
      if (bus.done === 1'b1) begin lat = k; break; end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    vectors++; if (bus.done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b want 0", bus.done); end
    vectors++; if (bus.div_by_zero !== 1'b0) begin miscompares++; $display("FAIL reset_dbz: got %b want 0", bus.div_by_zero); end
    vectors++; if (bus.hi !== 32'h0) begin miscompares++; $display("FAIL reset_hi: got %h want 0", bus.hi); end
    vectors++; if (bus.lo !== 32'h0) begin miscompares++; $display("FAIL reset_lo: got %h want 0", bus.lo); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_directed;
    logic [1:0]  ops [5] = '{2'b00, 2'b11, 2'b10, 2'b10, 2'b11};
    logic [31:0] as  [5] = '{32'hFFFFFFFD, 32'd100, 32'hFFFFFFF9, 32'h80000000, 32'd9};
    logic [31:0] bs  [5] = '{32'd7, 32'd7, 32'd2, 32'hFFFFFFFF, 32'd0};
    logic [31:0] his [5] = '{32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 32'd0, 32'd9};
    logic [31:0] los [5] = '{32'hFFFFFFEB, 32'd14, 32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFFF};
    int          lats[5] = '{34, 34, 34, 34, 1};
    int lat; bit bok;
    for (int i = 0; i < 5; i++) begin
      run_op(ops[i], as[i], bs[i], lat, bok);
      vectors++; if (lat != lats[i]) begin miscompares++; $display("FAIL dir%0d_latency: got %0d want %0d", i, lat, lats[i]); end
      vectors++; if (bus.hi !== his[i]) begin miscompares++; $display("FAIL dir%0d_hi: got %h want %h", i, bus.hi, his[i]); end
      vectors++; if (bus.lo !== los[i]) begin miscompares++; $display("FAIL dir%0d_lo: got %h want %h", i, bus.lo, los[i]); end
      vectors++; if (bok !== 1'b1) begin miscompares++; $display("FAIL dir%0d_busy: got %b want 1", i, bok); end
      vectors++; if (bus.div_by_zero !== (i == 4)) begin miscompares++; $display("FAIL dir%0d_dbz: got %b want %b", i, bus.div_by_zero, i == 4); end
      @(negedge clk);
      vectors++; if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin miscompares++; $display("FAIL dir%0d_after: got done=%b busy=%b want 0 0", i, bus.done, bus.busy); end
    end
    // Following MULTU clears the divide-by-zero flag.
    run_op(2'b01, 32'd2, 32'd3, lat, bok);
    vectors++; if (bus.div_by_zero !== 1'b0) begin miscompares++; $display("FAIL dbz_clear: got %b want 0", bus.div_by_zero); end
    vectors++; if ({bus.hi, bus.lo} !== 64'd6) begin miscompares++; $display("FAIL dbz_next_result: got %h want 6", {bus.hi, bus.lo}); end
    @(negedge clk);
  endtask

  task automatic test_early_out;
    int lat; bit bok; int want;
`ifdef MULDIV_EARLY_OUT_EN
    want = 5;
`else
    want = 34;
`endif
    run_op(2'b01, 32'd3, 32'd5, lat, bok);
    vectors++; if (lat != want) begin miscompares++; $display("FAIL early_out_latency: got %0d want %0d", lat, want); end
    vectors++; if ({bus.hi, bus.lo} !== 64'd15) begin miscompares++; $display("FAIL early_out_result: got %h want 15", {bus.hi, bus.lo}); end
    @(negedge clk);
  endtask

  task automatic test_random;
    logic [1:0] o; logic [31:0] x, y; logic [63:0] exp; int lat; bit bok;
    for (int i = 0; i < 40; i++) begin
      o = 2'($urandom_range(0, 3));
      x = $urandom;
      case ($urandom_range(0, 4))
        0: y = 32'd0;
        1: y = $urandom_range(1, 300);
        2: y = -($urandom_range(1, 300));
        default: y = $urandom;
      endcase
      if ($urandom_range(0, 5) == 0) x = 32'h80000000;
      exp = ref_result(o, x, y);
      run_op(o, x, y, lat, bok);
      vectors++; if ({bus.hi, bus.lo} !== exp) begin miscompares++; $display("FAIL rand%0d_result op=%0d a=%h b=%h: got %h want %h", i, o, x, y, {bus.hi, bus.lo}, exp); end
      vectors++; if (lat != ref_latency(o, y)) begin miscompares++; $display("FAIL rand%0d_latency op=%0d b=%h: got %0d want %0d", i, o, y, lat, ref_latency(o, y)); end
      vectors++; if (bus.div_by_zero !== (o[1] && y == 0)) begin miscompares++; $display("FAIL rand%0d_dbz: got %b want %b", i, bus.div_by_zero, o[1] && y == 0); end
      @(negedge clk);
    end
  endtask

  task automatic test_start_while_busy;
    int lat; logic [63:0] exp;
    bus.hi_we = 1'b1; bus.wdata = 32'h1234;
    @(negedge clk);
    bus.hi_we = 1'b0;
    vectors++; if (bus.hi !== 32'h1234) begin miscompares++; $display("FAIL mthi_idle: got %h want 00001234", bus.hi); end
    exp = ref_result(2'b00, 32'hDEADBEEF, 32'h00C0FFEE);
    bus.start = 1'b1; bus.op = 2'b00; bus.a = 32'hDEADBEEF; bus.b = 32'h00C0FFEE;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    bus.start = 1'b1; bus.op = 2'b01; bus.a = 32'd5; bus.b = 32'd5;
    bus.hi_we = 1'b1; bus.wdata = 32'h55;
    @(negedge clk);
    bus.start = 1'b0; bus.hi_we = 1'b0;
    vectors++; if (bus.hi !== 32'h1234) begin miscompares++; $display("FAIL mthi_busy_dropped: got %h want 00001234", bus.hi); end
    lat = -1;
    for (int k = 10; k < 100; k++) begin
      if (bus.done === 1'b1) begin lat = k; break; end
      @(negedge clk);
    end
    vectors++; if (lat != ref_latency(2'b00, 32'h00C0FFEE)) begin miscompares++; $display("FAIL busy_start_latency: got %0d want %0d", lat, ref_latency(2'b00, 32'h00C0FFEE)); end
    vectors++; if ({bus.hi, bus.lo} !== exp) begin miscompares++; $display("FAIL busy_start_result: got %h want %h", {bus.hi, bus.lo}, exp); end
    @(negedge clk);
    bus.hi_we = 1'b1; bus.wdata = 32'h55;
    @(negedge clk);
    bus.hi_we = 1'b0;
    vectors++; if (bus.hi !== 32'h55) begin miscompares++; $display("FAIL mthi_after: got %h want 00000055", bus.hi); end
    bus.lo_we = 1'b1; bus.wdata = 32'hA5A5A5A5;
    @(negedge clk);
    bus.lo_we = 1'b0;
    vectors++; if (bus.lo !== 32'hA5A5A5A5 || bus.hi !== 32'h55) begin miscompares++; $display("FAIL mtlo: got hi=%h lo=%h want 00000055 a5a5a5a5", bus.hi, bus.lo); end
    // Start in the same cycle as a write: start wins, write dropped.
    bus.start = 1'b1; bus.op = 2'b01; bus.a = 32'd1; bus.b = 32'd1;
    bus.hi_we = 1'b1; bus.wdata = 32'h77;
    @(negedge clk);
    bus.start = 1'b0; bus.hi_we = 1'b0;
    vectors++; if (bus.hi !== 32'h55) begin miscompares++; $display("FAIL start_beats_mthi: got %h want 00000055", bus.hi); end
    lat = -1;
    for (int k = 0; k < 100; k++) begin
      if (bus.done === 1'b1) begin lat = k; break; end
      @(negedge clk);
    end
    vectors++; if ({bus.hi, bus.lo} !== 64'd1 || lat < 0) begin miscompares++; $display("FAIL start_beats_mthi_result: got %h lat %0d want 1", {bus.hi, bus.lo}, lat); end
    @(negedge clk);
  endtask

  task automatic test_abort_reset;
    int lat; bit bok;
    bus.start = 1'b1; bus.op = 2'b10; bus.a = 32'd1000; bus.b = 32'd3;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (19) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    vectors++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin miscompares++; $display("FAIL abort_ctrl: got busy=%b done=%b want 0 0", bus.busy, bus.done); end
    vectors++; if (bus.hi !== 32'h0 || bus.lo !== 32'h0) begin miscompares++; $display("FAIL abort_hilo: got hi=%h lo=%h want 0 0", bus.hi, bus.lo); end
    rst = 1'b0;
    run_op(2'b10, 32'hFFFFFF9C, 32'd7, lat, bok);
    vectors++; if (lat != 34) begin miscompares++; $display("FAIL abort_restart_latency: got %0d want 34", lat); end
    vectors++; if ({bus.hi, bus.lo} !== ref_result(2'b10, 32'hFFFFFF9C, 32'd7)) begin miscompares++; $display("FAIL abort_restart_result: got %h want %h", {bus.hi, bus.lo}, ref_result(2'b10, 32'hFFFFFF9C, 32'd7)); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    logic [31:0] x, y; logic [63:0] exp; int lat; bit bok;
    for (int i = 0; i < 4; i++) begin
      x = $urandom; y = $urandom_range(1, 1000);
      exp = ref_result(2'(i), x, y);
      run_op(2'(i), x, y, lat, bok);
      vectors++; if ({bus.hi, bus.lo} !== exp) begin miscompares++; $display("FAIL b2b%0d_result: got %h want %h", i, {bus.hi, bus.lo}, exp); end
      // start during the done cycle is not in IDLE and must be ignored
      bus.start = 1'b1; bus.op = 2'b01; bus.a = 32'd9; bus.b = 32'd9;
      @(negedge clk);
      bus.start = 1'b0;
      vectors++; if (bus.busy !== 1'b0 || {bus.hi, bus.lo} !== exp) begin miscompares++; $display("FAIL b2b%0d_done_start: got busy=%b hilo=%h want 0 %h", i, bus.busy, {bus.hi, bus.lo}, exp); end
    end
  endtask

  initial begin
    bus.start = 1'b0; bus.op = 2'b00; bus.a = '0; bus.b = '0;
    bus.hi_we = 1'b0; bus.lo_we = 1'b0; bus.wdata = '0;
    test_reset();
    test_directed();
    test_early_out();
    test_random();
    test_start_while_busy();
    test_abort_reset();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
